// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if
//   Request/response bundle between the MEM stage (master) and the data
//   memory responder (slave).
//
//   Handshake: a request transfers on a rising clock edge where req_valid
//   and req_ready are both 1. The master may change or drop req_* at any
//   time; a request presented while req_ready=0 is simply not taken and is
//   not remembered. The response side has no backpressure: rsp_valid is a
//   single-cycle strobe, and rsp_rdata/rsp_err are meaningful while it is 1.
//
//   Signals
//     req_valid   master->slave  request present
//     req_ready   slave->master  responder can accept this cycle
//     req_we      master->slave  1 = store, 0 = load
//     req_size    master->slave  00 byte, 01 half, 10 word, 11 illegal
//     req_signed  master->slave  load sign-extension select
//     req_addr    master->slave  byte address
//     req_wdata   master->slave  store data (low lanes for sub-word stores)
//     rsp_valid   slave->master  one-cycle response strobe
//     rsp_rdata   slave->master  load result
//     rsp_err     slave->master  request rejected
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Data memory for the pipelined RISC-V core. Accepts one load/store at a
//   time, waits WAIT_CYCLES busy cycles, then answers with a one-cycle
//   response. Byte-addressed, little-endian, byte/half/word accesses with
//   sign or zero extension on sub-word loads. Misaligned, illegal-size and
//   out-of-range requests are answered with rsp_err=1 and have no effect.
//
//   Ports
//     clk        rising-edge clock
//     reset      asynchronous, active-low reset
//     bus        request/response channel (slave side)
//     dbg_addr   word address for the debug read (bits [1:0] ignored)
//     dbg_rdata  combinational word at dbg_addr, 0 when out of range
//     dbg_state  current FSM state (0 IDLE, 1 BUSY, 2 RESP)
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    data_mem_responder_if.slave        bus,
    input  logic [31:0]                dbg_addr,
    output logic [31:0]                dbg_rdata,
    output logic [1:0]                 dbg_state
);
    localparam int          AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int          CW         = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH_WORDS * 4);
    localparam bit          NO_WAIT    = (WAIT_CYCLES == 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] count;

    // Request captured on the accept edge
    logic          we_q;
    logic [1:0]    size_q;
    logic          sgn_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;

    // Request actually used for the access
    logic          e_we;
    logic [1:0]    e_size;
    logic          e_sgn;
    logic [31:0]   e_addr;
    logic [31:0]   e_wdata;

    logic [31:0]   mem [DEPTH_WORDS];

    logic          accept;
    logic          enter_resp;
    logic          in_range;
    logic          misaligned;
    logic          err;
    logic [AW-1:0] widx;
    logic [31:0]   cur_word;
    logic [7:0]    ld_byte;
    logic [15:0]   ld_half;
    logic [31:0]   load_data;
    logic [31:0]   lane_mask;
    logic [31:0]   store_word;
    logic [31:0]   rdata_next;
    logic          do_write;
    logic [31:0]   rsp_rdata_q;
    logic          rsp_err_q;

    assign accept = bus.req_valid && bus.req_ready;

    // The access is performed on the edge that moves the FSM into RESP. With
    // no wait states that is the accept edge, so the live inputs are used.
    assign enter_resp = NO_WAIT ? (state == IDLE && accept)
                                : (state == BUSY && count == CW'(1));

    assign e_we    = NO_WAIT ? bus.req_we     : we_q;
    assign e_size  = NO_WAIT ? bus.req_size   : size_q;
    assign e_sgn   = NO_WAIT ? bus.req_signed : sgn_q;
    assign e_addr  = NO_WAIT ? bus.req_addr   : addr_q;
    assign e_wdata = NO_WAIT ? bus.req_wdata  : wdata_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = NO_WAIT ? RESP : BUSY;
            BUSY:    if (count == CW'(1)) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.req_ready = (state == IDLE) && reset;
        bus.rsp_valid = (state == RESP);
        bus.rsp_rdata = rsp_rdata_q;
        bus.rsp_err   = rsp_err_q;
        dbg_state     = state;
    end

    // ---------------- wait counter and request capture ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == IDLE && accept) begin
            count   <= CW'(WAIT_CYCLES);
            we_q    <= bus.req_we;
            size_q  <= bus.req_size;
            sgn_q   <= bus.req_signed;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end else if (state == BUSY) begin
            count   <= count - CW'(1);
        end
    end

    // ---------------- access decode ----------------
    always_comb begin
        in_range = (e_addr < BYTE_LIMIT);
        widx     = e_addr[AW+1:2];
        cur_word = in_range ? mem[widx] : '0;

        case (e_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = e_addr[0];
            2'b10:   misaligned = |e_addr[1:0];
            default: misaligned = 1'b1;   // illegal size folds into the error
        endcase
        err = misaligned || !in_range;

        case (e_addr[1:0])
            2'b00:   ld_byte = cur_word[7:0];
            2'b01:   ld_byte = cur_word[15:8];
            2'b10:   ld_byte = cur_word[23:16];
            default: ld_byte = cur_word[31:24];
        endcase
        ld_half = e_addr[1] ? cur_word[31:16] : cur_word[15:0];

        case (e_size)
            2'b00:   load_data = {{24{e_sgn & ld_byte[7]}}, ld_byte};
            2'b01:   load_data = {{16{e_sgn & ld_half[15]}}, ld_half};
            default: load_data = cur_word;
        endcase

        // Byte lanes touched by a store; alignment is guaranteed when err=0
        case (e_size)
            2'b00:   lane_mask = 32'h0000_00FF << {e_addr[1:0], 3'b000};
            2'b01:   lane_mask = 32'h0000_FFFF << {e_addr[1:0], 3'b000};
            default: lane_mask = 32'hFFFF_FFFF;
        endcase
        store_word = (cur_word & ~lane_mask)
                   | ((e_wdata << {e_addr[1:0], 3'b000}) & lane_mask);

        rdata_next = (err || e_we) ? 32'h0 : load_data;
        do_write   = enter_resp && e_we && !err;
    end

    // ---------------- registered response ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else if (enter_resp) begin
            rsp_rdata_q <= rdata_next;
            rsp_err_q   <= err;
        end
    end

    // ---------------- storage (not reset) ----------------
    // The reset term keeps a store from landing on an edge sampled while
    // reset is held low.
    always_ff @(posedge clk) begin
        if (reset && do_write) begin
            mem[widx] <= store_word;
        end
    end

    assign dbg_rdata = (dbg_addr < BYTE_LIMIT) ? mem[dbg_addr[AW+1:2]] : 32'h0;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Self-checking bench for data_mem_responder. A byte-array reference model
//   produces the expected response of every accepted request; expected
//   responses wait in exp_q until the DUT answers.
module tb_data_mem_responder;
    localparam int DEPTH_WORDS  = 256;
    localparam int WAIT_CYCLES  = 2;
    localparam int MEM_BYTES    = DEPTH_WORDS * 4;
    localparam int REGION_BYTES = 128;   // initialised area used for loads

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_rdata;
    logic [1:0]  dbg_state;

    data_mem_responder_if bus();

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [32:0] exp_q[$];            // {err, rdata}
    logic [7:0]  ref_mem [MEM_BYTES];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [32:0] got, input logic [32:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: apply one request to the byte array and return the
    // response it must produce.
    function automatic logic [32:0] model_access(input logic we, input logic [1:0] size,
                                                 input logic sgn, input logic [31:0] addr,
                                                 input logic [31:0] wdata);
        logic [31:0] r;
        int          nbytes;
        int          a;
        nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        if (size == 2'd3 || addr >= MEM_BYTES || (addr % nbytes) != 0)
            return {1'b1, 32'h0};
        a = int'(addr);
        if (we) begin
            for (int i = 0; i < nbytes; i++) ref_mem[a + i] = wdata[8*i +: 8];
            return {1'b0, 32'h0};
        end
        r = 32'h0;
        for (int i = 0; i < nbytes; i++) r[8*i +: 8] = ref_mem[a + i];
        if (sgn && nbytes < 4 && r[8*nbytes-1])
            r = r | ~((32'd1 << (8 * nbytes)) - 32'd1);
        return {1'b0, r};
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        int a;
        if (addr >= MEM_BYTES) return 32'h0;
        a = int'(addr) & ~3;
        return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_req(input logic we, input logic [1:0] size, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wdata);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
    endtask

    // One full transaction from an idle channel: checks the handshake, the
    // response latency, and the response against the model.
    task automatic do_req(input string tag, input logic we, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [32:0] got);
        int   lat;
        bit   seen;
        @(negedge clk);
        check({tag, "_ready"}, {32'h0, bus.req_ready}, 33'd1);
        drive_req(we, size, sgn, addr, wdata);
        exp_q.push_back(model_access(we, size, sgn, addr, wdata));
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        seen = 1'b0;
        lat  = 0;
        got  = '0;
        for (int k = 1; k <= WAIT_CYCLES + 4 && !seen; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                seen = 1'b1;
                lat  = k;
                got  = {bus.rsp_err, bus.rsp_rdata};
            end
        end
        check({tag, "_latency"}, 33'(lat), 33'(WAIT_CYCLES + 1));
        check({tag, "_rsp"}, got, exp_q.pop_front());
        @(negedge clk);
        check({tag, "_rsp_drop"}, {32'h0, bus.rsp_valid}, 33'd0);
    endtask

    task automatic check_dbg(input string tag, input logic [31:0] addr);
        dbg_addr = addr;
        #1;
        check(tag, {1'b0, dbg_rdata}, {1'b0, ref_word(addr)});
    endtask

    task automatic gen_legal(output logic we, output logic [1:0] size, output logic sgn,
                             output logic [31:0] addr, output logic [31:0] wdata);
        we    = 1'($urandom_range(0, 1));
        size  = 2'($urandom_range(0, 2));
        sgn   = 1'($urandom_range(0, 1));
        addr  = 32'($urandom_range(0, REGION_BYTES - 1));
        wdata = $urandom();
        if (size == 2'd1) addr[0]   = 1'b0;
        if (size == 2'd2) addr[1:0] = 2'b00;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d",
                 n_checks, n_errors);
        $fatal(1, "time limit");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [32:0] got;
        logic        we, sgn;
        logic [1:0]  size;
        logic [31:0] addr, wdata, old_word;
        int          mode;

        reset          = 1'b0;
        dbg_addr       = 32'h0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;

        // Reset state
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ready", {32'h0, bus.req_ready}, 33'd0);
            check("rst_rsp_valid", {32'h0, bus.rsp_valid}, 33'd0);
            check("rst_rsp", {bus.rsp_err, bus.rsp_rdata}, 33'd0);
        end
        reset = 1'b1;
        @(negedge clk);
        check("rel_ready", {32'h0, bus.req_ready}, 33'd1);

        // Fill the load region with random words
        for (int w = 0; w < REGION_BYTES / 4; w++)
            do_req("init", 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom(), got);

        // Word store/load and debug port
        do_req("st_w10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, got);
        check("st_w10_const", got, 33'h0);
        do_req("ld_w10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, got);
        check("ld_w10_const", got, {1'b0, 32'hDEADBEEF});
        check_dbg("dbg_10", 32'h10);

        // Sub-word loads and a byte store
        do_req("ld_sb13", 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, got);
        check("ld_sb13_const", got, {1'b0, 32'hFFFFFFDE});
        do_req("ld_ub13", 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, got);
        check("ld_ub13_const", got, {1'b0, 32'h000000DE});
        do_req("ld_sh10", 1'b0, 2'd1, 1'b1, 32'h10, 32'h0, got);
        check("ld_sh10_const", got, {1'b0, 32'hFFFFBEEF});
        do_req("ld_uh12", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, got);
        check("ld_uh12_const", got, {1'b0, 32'h0000DEAD});
        do_req("st_b11", 1'b1, 2'd0, 1'b0, 32'h11, 32'hAAAAAA55, got);
        dbg_addr = 32'h10;
        #1 check("dbg_10_b11_const", {1'b0, dbg_rdata}, {1'b0, 32'hDEAD55EF});

        // Error cases
        do_req("err_ld_w12", 1'b0, 2'd2, 1'b0, 32'h12, 32'h0, got);
        check("err_ld_w12_const", got, {1'b1, 32'h0});
        do_req("err_st_400", 1'b1, 2'd2, 1'b0, 32'h400, 32'h12345678, got);
        check("err_st_400_const", got, {1'b1, 32'h0});
        check_dbg("dbg_400", 32'h400);
        check_dbg("dbg_000_untouched", 32'h0);
        do_req("err_size3", 1'b0, 2'd3, 1'b0, 32'h20, 32'h0, got);
        check("err_size3_const", got, {1'b1, 32'h0});

        // Back-to-back requests: only every (WAIT_CYCLES+2)th edge accepts
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("hs_ready", {32'h0, bus.req_ready}, {32'h0, (i % 4) == 0});
            check("hs_rsp_valid", {32'h0, bus.rsp_valid}, {32'h0, (i % 4) == 3});
            if (i % 4 == 3) check("hs_rsp", {bus.rsp_err, bus.rsp_rdata}, exp_q.pop_front());
            gen_legal(we, size, sgn, addr, wdata);
            drive_req(we, size, sgn, addr, wdata);
            if (i % 4 == 0) exp_q.push_back(model_access(we, size, sgn, addr, wdata));
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("hs_end_ready", {32'h0, bus.req_ready}, 33'd1);
        check("hs_end_rsp_valid", {32'h0, bus.rsp_valid}, 33'd0);
        check("hs_queue_empty", 33'(exp_q.size()), 33'd0);
        for (int w = 0; w < REGION_BYTES / 4; w++) check_dbg("hs_dbg", 32'(w * 4));

        // Randomized mix including illegal, misaligned and out-of-range
        for (int n = 0; n < 60; n++) begin
            gen_legal(we, size, sgn, addr, wdata);
            mode = $urandom_range(0, 9);
            if (mode == 0) begin
                size = 2'd3;
            end else if (mode == 1) begin
                addr = (n % 2 == 0) ? 32'(MEM_BYTES + 4 * $urandom_range(0, 255)) : ($urandom() | 32'h8000_0000);
                addr[1:0] = 2'b00;
            end else if (mode == 2) begin
                size = 2'($urandom_range(1, 2));
                if (size == 2'd1) addr[0] = 1'b1;
                else              addr[1:0] = 2'($urandom_range(1, 3));
            end
            do_req("rnd", we, size, sgn, addr, wdata, got);
            if (we) check_dbg("rnd_dbg", addr & 32'hFFFF_FFFC);
        end

        // Reset in the middle of a store: the write must never land
        old_word = ref_word(32'h20);
        @(negedge clk);
        drive_req(1'b1, 2'd2, 1'b0, 32'h20, 32'h11111111);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mid_rst_ready", {32'h0, bus.req_ready}, 33'd0);
            check("mid_rst_rsp_valid", {32'h0, bus.rsp_valid}, 33'd0);
            check("mid_rst_rsp", {bus.rsp_err, bus.rsp_rdata}, 33'd0);
        end
        dbg_addr = 32'h20;
        #1 check("mid_rst_dbg_20", {1'b0, dbg_rdata}, {1'b0, old_word});
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_ready", {32'h0, bus.req_ready}, 33'd1);
            check("post_rst_rsp_valid", {32'h0, bus.rsp_valid}, 33'd0);
        end
        check_dbg("post_rst_dbg_20", 32'h20);

        // Final sweep of the whole written region plus out-of-range reads
        for (int w = 0; w < REGION_BYTES / 4; w++) check_dbg("final_dbg", 32'(w * 4));
        check_dbg("final_dbg_oor", 32'hFFFF_FFFC);
        do_req("final_ld", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, got);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder for the pipelined RISC-V processor. It receives load/store requests from the MEM stage over a valid/ready request channel and answers each one with a single-cycle response pulse after a programmable number of wait states. It holds a byte-addressed, little-endian word array and performs byte, halfword and word accesses, with sign- or zero-extension on loads. A combinational debug read port lets benches inspect memory contents without disturbing the channel.

## Interface
- DEPTH_WORDS, 256, number of 32-bit words; valid byte addresses are 0 to DEPTH_WORDS*4-1
- WAIT_CYCLES, 2, number of BUSY cycles between request acceptance and response (0 allowed)
- clk  input  1  clock; all state changes occur on the rising edge
- reset  input  1  asynchronous, active-low reset; 0 = in reset
- req_valid  input  1  request present on the req_* lines
- req_ready  output  1  responder can accept a request this cycle
- req_we  input  1  1 = store, 0 = load
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  input  32  byte address
- req_wdata  input  32  store data; low bits are used for byte and halfword stores
- rsp_valid  output  1  one-cycle response strobe
- rsp_rdata  output  32  load result
- rsp_err  output  1  request rejected; valid only while rsp_valid=1
- dbg_addr  input  32  word-aligned byte address for the debug read; bits [1:0] are ignored
- dbg_rdata  output  32  combinational word read at dbg_addr; returns 0 if dbg_addr is out of range

## Operation
- States: IDLE, BUSY, RESP. Reset sets state=IDLE and count=0.
- req_ready = (state==IDLE) && reset. It is forced to 0 while reset is low.
- Accept: a request is accepted on a rising edge when req_valid && req_ready. The edge samples req_we, req_size, req_signed, req_addr and req_wdata. If req_valid is high while req_ready is low, the request is ignored and not queued.
- IDLE -> BUSY on accept, with count=WAIT_CYCLES. If WAIT_CYCLES=0, IDLE -> RESP directly.
- BUSY: count decrements on each edge. The edge where count==1 moves the state to RESP.
- RESP: lasts exactly one cycle, then returns to IDLE. There is no response backpressure.
- The memory access happens on the edge that enters RESP, using the sampled request. When WAIT_CYCLES=0 this is the accept edge itself, using the live inputs.
- Error check: rsp_err=1 when any of the following holds:
  - req_size==11
  - halfword with addr[0]=1
  - word with addr[1:0]!=0
  - addr >= DEPTH_WORDS*4
- On error: no write occurs and rsp_rdata=0.
- Stores write lanes selected by addr[1:0] (little-endian); other bytes are untouched. A store response carries rsp_rdata=0.
- Loads select a byte at addr[1:0] or a halfword at addr[1]. The result is extended to 32 bits according to req_signed. For word loads req_signed is ignored.
- rsp_rdata and rsp_err are registered. They are loaded on the edge entering RESP, hold their value until the next response, and read 0 when rsp_valid=0 is irrelevant.
- Memory contents are not affected by reset.

## Timing
- Outputs during and immediately after reset: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Accept on edge E0: state is BUSY during [E0, E0+WAIT_CYCLES), RESP during [E0+WAIT_CYCLES, E0+WAIT_CYCLES+1), and req_ready=1 again from edge E0+WAIT_CYCLES+1.
- Earliest next accept is edge E0+WAIT_CYCLES+2, so throughput is one request per WAIT_CYCLES+2 cycles.
- Reset asserted mid-operation: the state returns to IDLE immediately and rsp_valid drops. A store whose RESP-entry edge has not yet occurred is never written, and no response is ever issued for it.
- dbg_rdata reflects a write from the cycle after the writing edge.

## Test plan
- Reset: hold reset=0 -> req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. Release -> req_ready=1 in the next cycle.
- Latency and data (WAIT_CYCLES=2): store word 0xDEADBEEF to 0x10, then load word 0x10 -> rsp_valid high exactly in cycle [E0+2, E0+3) for each request, rsp_err=0, rsp_rdata=0xDEADBEEF, dbg_rdata(0x10)=0xDEADBEEF.
- Sub-word: with 0xDEADBEEF at 0x10:
  - signed byte load 0x13 -> 0xFFFFFFDE; unsigned byte load 0x13 -> 0x000000DE
  - signed half load 0x10 -> 0xFFFFBEEF; unsigned half load 0x12 -> 0x0000DEAD
  - byte store 0x55 to 0x11 -> word at 0x10 reads 0xDEAD55EF
- Errors:
  - word load 0x12 -> rsp_err=1, rsp_rdata=0
  - word store 0x12345678 to 0x400 -> rsp_err=1, memory unchanged
  - req_size=11 -> rsp_err=1
- Handshake: req_valid held high with a new request every cycle -> accepts occur only on every 4th edge (WAIT_CYCLES=2); requests presented while req_ready=0 are dropped.
- Reset mid-operation: store 0x11111111 to 0x20, assert reset one cycle after accept -> rsp_valid never rises, dbg_rdata(0x20) keeps its old value, and req_ready=0 until reset is released.
